// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the fetch/data memory port arbiter.
package mem_arb_pkg;

  localparam int DEF_ADDR_W = 10;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  typedef enum logic {
    SRC_IF = 1'b0,
    SRC_D  = 1'b1
  } src_e;

endpackage

// File: rtl/mem_arb_prio.sv
// Fixed data-over-fetch priority with a saturating starvation counter that
// hands the win to a waiting fetch after STARVE_MAX consecutive losses.
module mem_arb_prio
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic if_req,
  input  logic d_req,
  input  logic arb_point,
  output logic win_valid,
  output src_e win_id
);

  localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  logic [CW-1:0] starve_cnt;
  logic          starved;

  assign starved = (starve_cnt == CW'(STARVE_MAX));

  always_comb begin
    win_valid = if_req | d_req;
    win_id    = SRC_IF;
    if (d_req && !(if_req && starved)) begin
      win_id = SRC_D;
    end
  end

  // Only arbitration points move the counter; a fetch win clears it.
  always_ff @(posedge CLK) begin
    if (RST) begin
      starve_cnt <= '0;
    end else if (arb_point) begin
      if (!if_req || win_id == SRC_IF) begin
        starve_cnt <= '0;
      end else if (!starved) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous memory between fetch and data ports.
// Optional per-port grant/conflict counters are enabled by MEM_ARB_STATS_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [31:0]       stat_if_gnt,
  output logic [31:0]       stat_d_gnt,
  output logic [31:0]       stat_conflict
`endif
);

  if (MEM_LAT < 1 || MEM_LAT > 4) begin : g_lat_chk
    $error("mem_port_arbiter: MEM_LAT must be in 1..4");
  end
  if (STARVE_MAX < 1) begin : g_starve_chk
    $error("mem_port_arbiter: STARVE_MAX must be at least 1");
  end

  state_e            state;
  state_e            state_nxt;
  src_e              lat_id;
  logic [ADDR_W-1:0] lat_addr;
  logic              lat_we;
  logic [DATA_W-1:0] lat_wdata;
  logic [1:0]        wait_cnt;
  logic              last_wait;
  logic              arb_point;
  logic              issue;
  logic              win_valid;
  src_e              win_id;

  assign arb_point = (state == IDLE) || (state == RESP);
  assign issue     = (state == ISSUE);
  assign last_wait = (state == WAIT) && (wait_cnt == 2'(MEM_LAT - 1));

  mem_arb_prio #(
    .STARVE_MAX(STARVE_MAX)
  ) u_prio (
    .CLK      (CLK),
    .RST      (RST),
    .if_req   (if_req),
    .d_req    (d_req),
    .arb_point(arb_point),
    .win_valid(win_valid),
    .win_id   (win_id)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, RESP: state_nxt = win_valid ? ISSUE : IDLE;
      ISSUE:      state_nxt = lat_we ? IDLE : WAIT;
      WAIT:       state_nxt = last_wait ? RESP : WAIT;
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      lat_id    <= SRC_IF;
      lat_addr  <= '0;
      lat_we    <= 1'b0;
      lat_wdata <= '0;
      wait_cnt  <= '0;
      if_rdata  <= '0;
      d_rdata   <= '0;
    end else begin
      state <= state_nxt;
      if (arb_point && win_valid) begin
        lat_id <= win_id;
        if (win_id == SRC_D) begin
          lat_addr  <= d_addr;
          lat_we    <= d_we;
          lat_wdata <= d_wdata;
        end else begin
          lat_addr  <= if_addr;
          lat_we    <= 1'b0;
          lat_wdata <= '0;
        end
      end
      if (state == WAIT) begin
        wait_cnt <= last_wait ? 2'd0 : wait_cnt + 2'd1;
      end
      // mem_rdata is only meaningful on the final WAIT edge.
      if (last_wait) begin
        if (lat_id == SRC_D) begin
          d_rdata <= mem_rdata;
        end else begin
          if_rdata <= mem_rdata;
        end
      end
    end
  end

  assign busy      = (state != IDLE);
  assign if_gnt    = issue && (lat_id == SRC_IF);
  assign d_gnt     = issue && (lat_id == SRC_D);
  assign if_rvalid = (state == RESP) && (lat_id == SRC_IF);
  assign d_rvalid  = (state == RESP) && (lat_id == SRC_D);
  assign mem_en    = issue;
  assign mem_we    = issue && lat_we;
  assign mem_addr  = issue ? lat_addr : '0;
  assign mem_wdata = issue ? lat_wdata : '0;

`ifdef MEM_ARB_STATS_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      stat_if_gnt   <= '0;
      stat_d_gnt    <= '0;
      stat_conflict <= '0;
    end else begin
      if (if_gnt && stat_if_gnt != 32'hFFFF_FFFF) begin
        stat_if_gnt <= stat_if_gnt + 32'd1;
      end
      if (d_gnt && stat_d_gnt != 32'hFFFF_FFFF) begin
        stat_d_gnt <= stat_d_gnt + 32'd1;
      end
      if (arb_point && if_req && d_req && stat_conflict != 32'hFFFF_FFFF) begin
        stat_conflict <= stat_conflict + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: MEM_LAT=1 main instance plus a
// MEM_LAT=3 instance for latency timing; MEM_ARB_STATS_EN adds counter checks.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

  localparam int AW  = 10;
  localparam int DW  = 32;
  localparam int TMO = 80;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- main DUT (MEM_LAT=1) ----------------
  logic          if_req, if_gnt, if_rvalid;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          d_req, d_we, d_gnt, d_rvalid;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata, d_rdata;
  logic          mem_en, mem_we, busy;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
`ifdef MEM_ARB_STATS_EN
  logic [31:0]   stat_if_gnt, stat_d_gnt, stat_conflict;
`endif

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1), .STARVE_MAX(4)) u_dut (
    .CLK(clk), .RST(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
`ifdef MEM_ARB_STATS_EN
    , .stat_if_gnt(stat_if_gnt), .stat_d_gnt(stat_d_gnt), .stat_conflict(stat_conflict)
`endif
  );

  // ---------------- latency DUT (MEM_LAT=3), fetch only ----------------
  logic          if_req3, if_gnt3, if_rvalid3, d_gnt3, d_rvalid3;
  logic [AW-1:0] if_addr3, mem_addr3;
  logic [DW-1:0] if_rdata3, d_rdata3, mem_wdata3, mem_rdata3;
  logic          mem_en3, mem_we3, busy3;
`ifdef MEM_ARB_STATS_EN
  logic [31:0]   stat_if_gnt3, stat_d_gnt3, stat_conflict3;
`endif

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(3), .STARVE_MAX(4)) u_dut3 (
    .CLK(clk), .RST(rst),
    .if_req(if_req3), .if_addr(if_addr3), .if_gnt(if_gnt3), .if_rvalid(if_rvalid3), .if_rdata(if_rdata3),
    .d_req(1'b0), .d_we(1'b0), .d_addr(10'h000), .d_wdata(32'h0),
    .d_gnt(d_gnt3), .d_rvalid(d_rvalid3), .d_rdata(d_rdata3),
    .mem_en(mem_en3), .mem_we(mem_we3), .mem_addr(mem_addr3), .mem_wdata(mem_wdata3),
    .mem_rdata(mem_rdata3), .busy(busy3)
`ifdef MEM_ARB_STATS_EN
    , .stat_if_gnt(stat_if_gnt3), .stat_d_gnt(stat_d_gnt3), .stat_conflict(stat_conflict3)
`endif
  );

  // ---------------- memory models ----------------
  // Read data is valid for exactly one cycle; other cycles show junk so a
  // capture on the wrong edge is visible.
  function automatic logic [DW-1:0] pat(input int i);
    if (i == 4) return 32'h0000_0013;
    return (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] exp_mem [0:(1<<AW)-1];
  logic          mem_init_done = 1'b0;
  logic [DW-1:0] rd_pipe;
  logic [DW-1:0] rd_pipe3 [0:2];

  always @(posedge clk) begin
    if (!mem_init_done) begin
      for (int i = 0; i < (1<<AW); i++) mem[i] <= pat(i);
      mem_init_done <= 1'b1;
    end else if (mem_en && mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
    rd_pipe <= (mem_en && !mem_we) ? mem[mem_addr] : 32'hBAD0_BAD0;
  end
  assign mem_rdata = rd_pipe;

  always @(posedge clk) begin
    rd_pipe3[0] <= (mem_en3 && !mem_we3) ? mem[mem_addr3] : 32'hBAD3_BAD3;
    rd_pipe3[1] <= rd_pipe3[0];
    rd_pipe3[2] <= rd_pipe3[1];
  end
  assign mem_rdata3 = rd_pipe3[2];

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [DW-1:0] if_exp_q[$];
  logic [DW-1:0] d_exp_q[$];
  logic          glog[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  int            if_gnt_cyc, d_gnt_cyc, if_rv_cyc, d_rv_cyc, if_rv_cnt, d_rv_cnt;
  logic          g_en, g_we;
  logic [AW-1:0] g_addr;
  logic [DW-1:0] g_wdata;
  int            if_gnt3_cyc, if_rv3_cyc, if_rv3_cnt;
  logic [DW-1:0] rv3_data;

  always @(negedge clk) begin
    if (if_gnt || d_gnt) begin
      check("gnt_excl", 32'(if_gnt & d_gnt), 0);
      glog.push_back(d_gnt);
      if (if_gnt) if_gnt_cyc = cyc;
      if (d_gnt)  d_gnt_cyc  = cyc;
      g_en = mem_en; g_we = mem_we; g_addr = mem_addr; g_wdata = mem_wdata;
    end
    if (if_rvalid || d_rvalid) check("rv_excl", 32'(if_rvalid & d_rvalid), 0);
    if (if_rvalid) begin
      if_rv_cyc = cyc;
      if_rv_cnt++;
      check("if_sb_nonempty", 32'(if_exp_q.size() != 0), 1);
      if (if_exp_q.size() != 0) check("if_rdata", if_rdata, if_exp_q.pop_front());
    end
    if (d_rvalid) begin
      d_rv_cyc = cyc;
      d_rv_cnt++;
      check("d_sb_nonempty", 32'(d_exp_q.size() != 0), 1);
      if (d_exp_q.size() != 0) check("d_rdata", d_rdata, d_exp_q.pop_front());
    end
    if (if_gnt3) if_gnt3_cyc = cyc;
    if (if_rvalid3) begin
      if_rv3_cyc = cyc;
      if_rv3_cnt++;
      rv3_data = if_rdata3;
    end
  end

  // ---------------- driver tasks (enter and leave at posedge+1) ----------------
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic fetch_read(input logic [AW-1:0] a, output int t0);
    int n;
    if_req = 1'b1; if_addr = a; t0 = cyc;
    if_exp_q.push_back(exp_mem[a]);
    n = 0;
    do begin @(negedge clk); n++; end while (!if_gnt && n < TMO);
    check("if_gnt_seen", 32'(if_gnt), 1);
    @(posedge clk); #1;
    if_req = 1'b0;
  endtask

  task automatic d_op(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd, output int t0);
    int n;
    d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd; t0 = cyc;
    if (we) exp_mem[a] = wd;
    else    d_exp_q.push_back(exp_mem[a]);
    n = 0;
    do begin @(negedge clk); n++; end while (!d_gnt && n < TMO);
    check("d_gnt_seen", 32'(d_gnt), 1);
    @(posedge clk); #1;
    d_req = 1'b0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int t0, t_if, t_d, rv0, n;
    logic [6:0] seq;
    rst = 1'b1;
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    if_req3 = 1'b0; if_addr3 = '0;
    for (int i = 0; i < (1<<AW); i++) exp_mem[i] = pat(i);
    if_rv_cnt = 0; d_rv_cnt = 0; if_rv3_cnt = 0;

    idle(3);
    @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_strobes", 32'({if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_we}), 0);
    check("rst_rdata", if_rdata | d_rdata, 0);
    check("rst_mem_bus", 32'(mem_addr) | mem_wdata, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(2);

    // Fetch read: gnt T+1 with memory strobe, rvalid T+3.
    fetch_read(10'h004, t0);
    idle(3);
    check("fr_gnt_lat", 32'(if_gnt_cyc - t0), 1);
    check("fr_mem_en", 32'(g_en), 1);
    check("fr_mem_we", 32'(g_we), 0);
    check("fr_mem_addr", 32'(g_addr), 32'h004);
    check("fr_rv_lat", 32'(if_rv_cyc - t0), 3);
    check("fr_rdata_hold", if_rdata, 32'h0000_0013);

    // Data write: gnt/mem_we T+1, idle at T+2, no rvalid.
    rv0 = d_rv_cnt;
    d_op(1'b1, 10'h100, 32'hDEAD_BEEF, t0);
    @(negedge clk);
    check("wr_busy_t2", 32'(busy), 0);
    check("wr_gnt_lat", 32'(d_gnt_cyc - t0), 1);
    check("wr_mem_en", 32'(g_en), 1);
    check("wr_mem_we", 32'(g_we), 1);
    check("wr_mem_addr", 32'(g_addr), 32'h100);
    check("wr_mem_wdata", g_wdata, 32'hDEAD_BEEF);
    idle(4);
    check("wr_no_rvalid", 32'(d_rv_cnt), 32'(rv0));
    d_op(1'b0, 10'h100, '0, t0);
    idle(3);

    // Conflict: data first, fetch arbitrated at data's RESP.
    fork
      fetch_read(10'h008, t_if);
      d_op(1'b0, 10'h200, '0, t_d);
    join
    idle(6);
    check("cf_d_gnt", 32'(d_gnt_cyc - t_d), 1);
    check("cf_d_rv", 32'(d_rv_cyc - t_d), 3);
    check("cf_if_gnt", 32'(if_gnt_cyc - t_if), 4);
    check("cf_if_rv", 32'(if_rv_cyc - t_if), 6);
`ifdef MEM_ARB_STATS_EN
    check("stat_conflict", stat_conflict, 1);
    check("stat_if_gnt", stat_if_gnt, 2);
    check("stat_d_gnt", stat_d_gnt, 3);
`endif

    // Starvation: four data grants, then fetch, then data resumes.
    glog.delete();
    fork
      fetch_read(10'h00C, t_if);
      begin : starve_data
        int td;
        for (int k = 0; k < 6; k++) d_op(1'b0, 10'(300 + k), '0, td);
      end
    join
    idle(8);
    seq = 7'b1101111;
    check("starve_len", 32'(glog.size()), 7);
    for (int k = 0; k < 7; k++) begin
      check("starve_seq", (k < glog.size()) ? 32'(glog[k]) : 32'hFFFF_FFFF, 32'(seq[k]));
    end

    // Reset during WAIT: no rvalid afterwards, outputs cleared.
    rv0 = if_rv_cnt;
    if_req = 1'b1; if_addr = 10'h010;
    @(posedge clk); #1;
    @(negedge clk);
    check("rr_gnt", 32'(if_gnt), 1);
    @(posedge clk); #1;
    if_req = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rr_busy", 32'(busy), 0);
    check("rr_strobes", 32'({if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_we}), 0);
    check("rr_if_rdata", if_rdata, 0);
    check("rr_d_rdata", d_rdata, 0);
    idle(6);
    check("rr_no_rvalid", 32'(if_rv_cnt), 32'(rv0));
    fetch_read(10'h014, t0);
    idle(4);
    check("rr_fresh_rv", 32'(if_rv_cyc - t0), 3);
`ifdef MEM_ARB_STATS_EN
    check("rr_stat_if", stat_if_gnt, 1);
`endif

    // MEM_LAT=3 instance: gnt T+1, rvalid T+5.
    if_req3 = 1'b1; if_addr3 = 10'h004; t0 = cyc;
    n = 0;
    do begin @(negedge clk); n++; end while (!if_gnt3 && n < TMO);
    check("l3_gnt_seen", 32'(if_gnt3), 1);
    @(posedge clk); #1;
    if_req3 = 1'b0;
    idle(8);
    check("l3_gnt_lat", 32'(if_gnt3_cyc - t0), 1);
    check("l3_rv_lat", 32'(if_rv3_cyc - t0), 5);
    check("l3_rdata", rv3_data, 32'h0000_0013);
    check("l3_rv_cnt", 32'(if_rv3_cnt), 1);

    // Random concurrent traffic; fetch and data use disjoint address ranges.
    fork
      begin : rnd_fetch
        int tf;
        for (int k = 0; k < 24; k++) begin
          fetch_read(10'($urandom_range(0, 255)), tf);
          idle($urandom_range(0, 3));
        end
      end
      begin : rnd_data
        int td;
        logic [AW-1:0] a;
        for (int k = 0; k < 24; k++) begin
          a = 10'($urandom_range(256, 1023));
          if ($urandom_range(0, 1) == 1) d_op(1'b1, a, $urandom, td);
          else                           d_op(1'b0, a, '0, td);
          if (k % 3 == 2) d_op(1'b0, a, '0, td);
          idle($urandom_range(0, 3));
        end
      end
    join
    idle(10);
    check("if_q_drained", 32'(if_exp_q.size()), 0);
    check("d_q_drained", 32'(d_exp_q.size()), 0);
    check("end_idle", 32'(busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
